uart_mmio: RTL and testbench
============================

# uart_mmio

Memory-mapped UART peripheral that answers the bus decoder's UART window. It drives the decoder's `uart_out` read data and consumes its read/write strobes. The receive path buffers incoming bytes in a small FIFO so software polling through the bus does not lose characters. The transmit path serialises one byte at a time from a holding register.

## Interface
Parameters:
- `CLK_HZ`, 27000000, core clock frequency.
- `BAUD`, 115200, reset baud rate; the default divider is `CLK_HZ/BAUD` (234).
- `RX_DEPTH`, 16, RX FIFO entries; must be a power of two, ≥2.

Ports:
- `clk` in 1: core clock.
- `resetn` in 1: asynchronous, active-low reset.
- `uart_ren` in 1: read strobe from the bus.
- `uart_wen` in 1: write strobe from the bus.
- `addr` in 4: byte offset within the UART window (`data_addr[3:0]`).
- `wdata` in 32: write data.
- `uart_out` out 32: registered read data.
- `rx` in 1: serial input, asynchronous.
- `tx` out 1: serial output, idle high.

## Operation
- Register map; offsets that are not word-aligned alias down to the aligned offset:
  - 0x0 DATA. A read pops the RX FIFO, returning `{valid, 23'b0, byte}`; `valid` = 0 and the byte = 0 when the FIFO is empty. A write loads `wdata[7:0]` into TX if the transmitter is idle, and is silently dropped if it is busy.
  - 0x4 STATUS, read-only: bit0 `rx_not_empty`, bit1 `rx_full`, bit2 `tx_busy`, bit3 `rx_overrun` (sticky), bit4 `frame_err` (sticky). Reading STATUS clears bits 3 and 4.
  - 0x8 DIVIDER: `clk` cycles per bit, bits [15:0], read/write. Written values below 8 are clamped to 8.
  - 0xC: reads 0, writes ignored.
- RX front end:
  - 2-flop synchroniser on `rx`.
  - States IDLE→START→DATA→STOP→IDLE.
  - IDLE→START on a synchronised falling edge.
  - START samples at DIV/2. If the line is high, the edge was a glitch and the FSM returns to IDLE.
  - DATA takes 8 samples, one every DIV cycles, LSB first.
  - STOP samples once. If high, the byte is pushed to the FIFO. If low, the byte is discarded and `frame_err` is set.
- FIFO rules:
  - A push while full drops the byte and sets `rx_overrun`.
  - A push and pop in the same cycle both take effect and the count is unchanged. When the FIFO is full this counts as no overrun.
  - A pop while empty changes nothing.
- TX FSM:
  - States IDLE→START→DATA→STOP→IDLE, each bit lasting DIV cycles, LSB first.
  - `tx_busy` = state ≠ IDLE.
- The divider is latched per frame at the START transition, separately for RX and TX. A DIVIDER write mid-frame affects only the next frame.

## Timing
- Reset values: `tx`=1, `uart_out`=0, FIFO empty, all flags 0, DIVIDER=`CLK_HZ/BAUD`, both FSMs IDLE.
- Read latency is 1: a strobe in cycle N gives `uart_out` valid in N+1 and held until the next strobe. A FIFO pop commits at the edge ending cycle N.
- TX write in cycle N:
  - `tx` falls in N+1.
  - The stop bit ends at N+1+10·DIV.
  - `tx_busy` reads 0 from that cycle on.
- RX: `rx_not_empty` asserts 1 cycle after the stop-bit sample, which is about 9.5·DIV + 3 cycles after the line falls.
- `resetn` asserted mid-frame:
  - Both FSMs return to IDLE immediately and `tx` goes high.
  - FIFO contents are lost.
  - A partially received frame is discarded. The RX FSM resynchronises only on the next falling edge after reset release; a line that is already low is ignored.

## Configuration
- `UART_LOOPBACK_EN`:
  - Defined: the RX synchroniser input is the internal `tx` instead of the `rx` pin, and the `tx` pin is held at 1. STATUS bit5 reads 1.
  - Undefined: `rx` pin feeds RX, `tx` drives the pin, and STATUS bit5 reads 0.

## Structure
- Shared header alongside the existing address defines:
  - register offsets 0x0/0x4/0x8;
  - STATUS bit indices;
  - FSM state encodings IDLE/START/DATA/STOP;
  - divider minimum 8.
- Sub-module `uart_rx_fifo`: synchronous FIFO parameterised by `RX_DEPTH`, with push/pop/full/empty and simultaneous push-pop support.
- The top instantiates it and holds the RX FSM, TX FSM, register file and read mux.

## Test plan
- Reset only, then read STATUS: `uart_out`=0x00000000, `tx`=1.
- Set DIVIDER=8, write DATA=0x55: `tx` waveform is 0,1,0,1,0,1,0,1,0,1 at 8 cycles per bit, then `tx_busy` clears at N+81.
- Drive an `rx` frame for 0xA3 at DIV=8, then read DATA: 0x800000A3. A second read returns 0x00000000.
- Send 17 frames with no reads (`RX_DEPTH`=16): STATUS=0x0B. After the STATUS read, STATUS=0x03. Then 16 DATA reads return the first 16 bytes in order.
- Stop bit driven low on byte 0x12: FIFO stays empty and STATUS=0x10. Separately, a 2-cycle low glitch: no byte and no flags.
- With `UART_LOOPBACK_EN`, write DATA=0x3C and wait 11·DIV cycles: the DATA read returns 0x8000003C, and the `tx` pin stays 1 throughout.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the uart_mmio peripheral: register offsets, STATUS bit
// positions, FSM state encoding and the divider floor.
package uart_mmio_pkg;

   localparam logic [3:0] OFF_DATA   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_DIV    = 4'h8;

   localparam int ST_RX_NE   = 0;
   localparam int ST_RX_FULL = 1;
   localparam int ST_TX_BUSY = 2;
   localparam int ST_OVERRUN = 3;
   localparam int ST_FRAME   = 4;
   localparam int ST_LOOP    = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_e;

   localparam logic [15:0] DIV_MIN = 16'd8;

   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < DIV_MIN) ? DIV_MIN : v;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for received characters; a pop and a push in the same
// cycle both take effect, so a full FIFO can accept a byte while being drained.
module uart_rx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [7:0]    mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         cnt_d    = cnt_d + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d    = cnt_d - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: DATA/STATUS/DIVIDER registers, RX FSM feeding a FIFO and
// a single-byte TX FSM. Define UART_LOOPBACK_EN to route internal tx into RX.
module uart_mmio
   import uart_mmio_pkg::*;
#(
   parameter int CLK_HZ   = 27000000,
   parameter int BAUD     = 115200,
   parameter int RX_DEPTH = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        uart_ren,
   input  logic        uart_wen,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] uart_out,
   input  logic        rx,
   output logic        tx
);

   localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);

`ifdef UART_LOOPBACK_EN
   localparam logic LOOP_EN = 1'b1;
`else
   localparam logic LOOP_EN = 1'b0;
`endif

   logic [15:0] div_q, div_d;
   logic [31:0] uart_out_q, uart_out_d;
   logic        ovr_q, ovr_d, ferr_q, ferr_d;
   logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
   logic        rx_in, rx_fall, rx_stop_smp, rx_push, ferr_set;
   logic        fifo_pop, stat_rd, tx_load;
   logic        fifo_full, fifo_empty;
   logic [7:0]  fifo_rdata;
   logic [3:0]  word;
   logic [31:0] status, rd_data;

   uart_state_e rx_st_q, tx_st_q;
   logic [15:0] rx_cnt_q, rx_div_q, tx_cnt_q, tx_div_q;
   logic [2:0]  rx_bit_q, tx_bit_q;
   logic [7:0]  rx_sh_q, tx_sh_q;
   logic        tx_q;

   logic unused_bits;
   assign unused_bits = ^{wdata[31:16], addr[1:0]};

`ifdef UART_LOOPBACK_EN
   assign rx_in = tx_q;
   assign tx    = 1'b1;
`else
   assign rx_in = rx;
   assign tx    = tx_q;
`endif

   assign uart_out = uart_out_q;

   // Synchroniser resets low so a line already low at reset release never looks like an edge.
   always_comb begin
      rx_s1_d   = rx_in;
      rx_s2_d   = rx_s1_q;
      rx_prev_d = rx_s2_q;
      rx_fall   = rx_prev_q & ~rx_s2_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_st_q  <= S_IDLE;
         rx_cnt_q <= '0;
         rx_div_q <= DIV_MIN;
         rx_bit_q <= '0;
         rx_sh_q  <= '0;
      end else begin
         unique case (rx_st_q)
            S_IDLE: if (rx_fall) begin
               rx_st_q  <= S_START;
               rx_cnt_q <= '0;
               rx_div_q <= div_q;
            end
            S_START: if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
               rx_cnt_q <= '0;
               rx_bit_q <= '0;
               rx_st_q  <= rx_s2_q ? S_IDLE : S_DATA;
            end else rx_cnt_q <= rx_cnt_q + 16'd1;
            S_DATA: if (rx_cnt_q == rx_div_q - 16'd1) begin
               rx_cnt_q <= '0;
               rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
               rx_bit_q <= rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
            end else rx_cnt_q <= rx_cnt_q + 16'd1;
            S_STOP: if (rx_stop_smp) begin
               rx_cnt_q <= '0;
               rx_st_q  <= S_IDLE;
            end else rx_cnt_q <= rx_cnt_q + 16'd1;
            default: rx_st_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_st_q  <= S_IDLE;
         tx_q     <= 1'b1;
         tx_cnt_q <= '0;
         tx_div_q <= DIV_MIN;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
      end else begin
         unique case (tx_st_q)
            S_IDLE: if (tx_load) begin
               tx_st_q  <= S_START;
               tx_q     <= 1'b0;
               tx_cnt_q <= '0;
               tx_div_q <= div_q;
               tx_sh_q  <= wdata[7:0];
            end
            S_START: if (tx_cnt_q == tx_div_q - 16'd1) begin
               tx_cnt_q <= '0;
               tx_bit_q <= '0;
               tx_q     <= tx_sh_q[0];
               tx_st_q  <= S_DATA;
            end else tx_cnt_q <= tx_cnt_q + 16'd1;
            S_DATA: if (tx_cnt_q == tx_div_q - 16'd1) begin
               tx_cnt_q <= '0;
               if (tx_bit_q == 3'd7) begin
                  tx_q    <= 1'b1;
                  tx_st_q <= S_STOP;
               end else begin
                  tx_q     <= tx_sh_q[1];
                  tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                  tx_bit_q <= tx_bit_q + 3'd1;
               end
            end else tx_cnt_q <= tx_cnt_q + 16'd1;
            S_STOP: if (tx_cnt_q == tx_div_q - 16'd1) begin
               tx_cnt_q <= '0;
               tx_st_q  <= S_IDLE;
            end else tx_cnt_q <= tx_cnt_q + 16'd1;
            default: tx_st_q <= S_IDLE;
         endcase
      end
   end

   uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (rx_push),
      .pop    (fifo_pop),
      .wdata  (rx_sh_q),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // Sticky flags: a set in the same cycle as the clearing STATUS read wins.
   always_comb begin
      word        = {addr[3:2], 2'b00};
      rx_stop_smp = (rx_st_q == S_STOP) && (rx_cnt_q == rx_div_q - 16'd1);
      rx_push     = rx_stop_smp & rx_s2_q;
      ferr_set    = rx_stop_smp & ~rx_s2_q;
      fifo_pop    = uart_ren && (word == OFF_DATA);
      stat_rd     = uart_ren && (word == OFF_STATUS);
      tx_load     = uart_wen && (word == OFF_DATA) && (tx_st_q == S_IDLE);

      div_d = div_q;
      if (uart_wen && (word == OFF_DIV)) div_d = clamp_div(wdata[15:0]);

      ovr_d  = (ovr_q & ~stat_rd) | (rx_push & fifo_full & ~fifo_pop);
      ferr_d = (ferr_q & ~stat_rd) | ferr_set;

      status             = '0;
      status[ST_RX_NE]   = ~fifo_empty;
      status[ST_RX_FULL] = fifo_full;
      status[ST_TX_BUSY] = (tx_st_q != S_IDLE);
      status[ST_OVERRUN] = ovr_q;
      status[ST_FRAME]   = ferr_q;
      status[ST_LOOP]    = LOOP_EN;

      unique case (word)
         OFF_DATA:   rd_data = fifo_empty ? 32'h0 : {1'b1, 23'b0, fifo_rdata};
         OFF_STATUS: rd_data = status;
         OFF_DIV:    rd_data = {16'b0, div_q};
         default:    rd_data = 32'h0;
      endcase

      uart_out_d = uart_out_q;
      if (uart_ren) uart_out_d = rd_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q      <= DIV_RST;
         uart_out_q <= '0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         rx_s1_q    <= 1'b0;
         rx_s2_q    <= 1'b0;
         rx_prev_q  <= 1'b0;
      end else begin
         div_q      <= div_d;
         uart_out_q <= uart_out_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         rx_s1_q    <= rx_s1_d;
         rx_s2_q    <= rx_s2_d;
         rx_prev_q  <= rx_prev_d;
      end
   end

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: reads push expected words into a queue that a
// monitor drains one cycle later; expectations come from a queue-based model.
module tb_uart_mmio;

`ifdef UART_LOOPBACK_EN
   localparam logic LB = 1'b1;
`else
   localparam logic LB = 1'b0;
`endif
   localparam int DEPTH   = 16;
   localparam int DIV_RST = 27000000 / 115200;

   logic        clk = 1'b0, resetn = 1'b0, uart_ren = 1'b0, uart_wen = 1'b0, rx = 1'b1;
   logic [3:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] uart_out;
   logic        tx;

   uart_mmio #(.CLK_HZ(27000000), .BAUD(115200), .RX_DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .uart_ren(uart_ren), .uart_wen(uart_wen),
      .addr(addr), .wdata(wdata), .uart_out(uart_out), .rx(rx), .tx(tx)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [31:0] v; string nm; } exp_t;
   exp_t       expq[$];
   logic       rd_pend = 1'b0;
   logic [7:0] mq[$];
   logic       m_ovr = 0, m_ferr = 0;
   int         m_div = DIV_RST, tx_free = 0;

   always @(posedge clk) rd_pend <= uart_ren;

   always @(negedge clk) begin
      if (rd_pend) begin
         n_vec++;
         if (expq.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected got=%08h", uart_out);
         end else begin
            exp_t e;
            e = expq.pop_front();
            if (uart_out !== e.v) begin
               n_err++;
               $display("FAIL %s got=%08h exp=%08h (t=%0t)", e.nm, uart_out, e.v, $time);
            end
         end
      end
   end

`ifdef UART_LOOPBACK_EN
   always @(negedge clk) begin
      n_vec++;
      if (tx !== 1'b1) begin
         n_err++;
         $display("FAIL lb_tx_pin got=%b exp=1 (t=%0t)", tx, $time);
      end
   end
`endif

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%08h exp=%08h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic goto_cyc(input int t);
      while (cyc < t) step();
   endtask

   task automatic m_push(input logic [7:0] b);
      if (mq.size() == DEPTH) m_ovr = 1'b1;
      else mq.push_back(b);
   endtask

   function automatic logic [31:0] m_status();
      logic busy;
      busy = (cyc < tx_free);
      return {26'b0, LB, m_ferr, m_ovr, busy, mq.size() == DEPTH, mq.size() != 0};
   endfunction

   task automatic rd(input logic [3:0] a, input string nm);
      exp_t e;
      e.nm = nm;
      case (a[3:2])
         2'd0: e.v = (mq.size() != 0) ? {1'b1, 23'b0, mq.pop_front()} : 32'h0;
         2'd1: begin e.v = m_status(); m_ovr = 0; m_ferr = 0; end
         2'd2: e.v = 32'(m_div);
         default: e.v = 32'h0;
      endcase
      expq.push_back(e);
      uart_ren = 1'b1; addr = a;
      step();
      uart_ren = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      case (a[3:2])
         2'd0: if (cyc >= tx_free) begin
            tx_free = cyc + 1 + 10 * m_div;
            if (LB) m_push(d[7:0]);
         end
         2'd2: m_div = (d[15:0] < 16'd8) ? 8 : int'(d[15:0]);
         default: ;
      endcase
      uart_wen = 1'b1; addr = a; wdata = d;
      step();
      uart_wen = 1'b0;
   endtask

   task automatic model_reset();
      mq.delete(); m_ovr = 0; m_ferr = 0; m_div = DIV_RST; tx_free = 0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_ok);
      rx = 1'b0; repeat (m_div) step();
      for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (m_div) step(); end
      rx = stop_ok; repeat (m_div) step();
      rx = 1'b1; repeat (4) step();
      if (stop_ok) m_push(b); else m_ferr = 1'b1;
   endtask

   task automatic glitch();
      rx = 1'b0; repeat (2) step();
      rx = 1'b1; repeat (2 * m_div) step();
   endtask

   // Bit-centre checks of one TX frame plus the exact tx_busy release cycle.
   task automatic tx_frame(input logic [7:0] b);
      int n, d;
      logic [9:0] fr;
      goto_cyc(tx_free);
      n = cyc; d = m_div; fr = {1'b1, b, 1'b0};
      tx_free = n + 1 + 10 * d;
      uart_wen = 1'b1; addr = 4'h0; wdata = {24'h0, b};
      @(negedge clk) check("tx_idle_before", {31'b0, tx}, 32'd1);
      step(); uart_wen = 1'b0;
      @(negedge clk) check("tx_fall_n1", {31'b0, tx}, 32'd0);
      for (int k = 0; k < 10; k++) begin
         goto_cyc(n + 1 + k * d + d / 2);
         @(negedge clk) check($sformatf("tx_bit%0d", k), {31'b0, tx}, {31'b0, fr[k]});
         if (k == 3) begin step(); wr(4'h0, {24'h0, ~b}); end
      end
      goto_cyc(n + 10 * d);
      rd(4'h4, "st_busy_last");
      rd(4'h4, "st_busy_clear");
   endtask

   initial begin
      repeat (3) step();
      resetn = 1'b1;
      @(negedge clk);
      check("rst_uart_out", uart_out, 32'h0);
      check("rst_tx", {31'b0, tx}, 32'd1);
      step();
      rd(4'h4, "rst_status");
      rd(4'h8, "rst_div");
      wr(4'h8, 32'd3);
      rd(4'h9, "div_clamp");
      wr(4'h8, 32'd8);
`ifdef UART_LOOPBACK_EN
      wr(4'h0, 32'h3C);
      repeat (11 * m_div) step();
      rd(4'h0, "lb_data");
      rd(4'h4, "lb_status");
      for (int i = 0; i < 6; i++) begin
         wr(4'h8, 32'($urandom_range(8, 12)));
         wr(4'h0, $urandom);
         repeat (11 * m_div) step();
         rd(4'(4 * $urandom_range(0, 1)), "lb_rand");
      end
      rd(4'h0, "lb_final");
`else
      tx_frame(8'h55);
      send_rx(8'hA3, 1'b1);
      rd(4'h0, "rx_a3");
      rd(4'h0, "rx_empty");
      for (int i = 0; i < 17; i++) send_rx(8'($urandom), 1'b1);
      rd(4'h4, "st_overrun");
      rd(4'h4, "st_after_clr");
      for (int i = 0; i < 17; i++) rd(4'h0, "drain");
      send_rx(8'h12, 1'b0);
      rd(4'h4, "st_frame_err");
      rd(4'h0, "ferr_no_byte");
      glitch();
      rd(4'h4, "st_glitch");
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 8))
            0, 1: send_rx(8'($urandom), 1'b1);
            2: send_rx(8'($urandom), 1'b0);
            3: glitch();
            4: rd(4'($urandom_range(0, 3)), "rnd_data");
            5: rd(4'($urandom_range(4, 7)), "rnd_status");
            6: begin
               wr(4'($urandom_range(8, 11)), 32'($urandom_range(0, 14)) | 32'hABCD_0000);
               rd(4'h8, "rnd_div");
            end
            7: begin wr(4'hC, $urandom); rd(4'($urandom_range(12, 15)), "rnd_rsvd"); end
            default: tx_frame(8'($urandom));
         endcase
      end
      for (int i = 0; i < 17; i++) rd(4'h0, "rnd_drain");
      rd(4'h4, "rnd_final_st");
      // Reset mid-frame with the rx line held low across release.
      goto_cyc(tx_free);
      wr(4'h0, 32'hF0);
      repeat (3 * m_div) step();
      rx = 1'b0;
      repeat (m_div) step();
      resetn = 1'b0;
      #1 check("rst_mid_tx", {31'b0, tx}, 32'd1);
      model_reset();
      repeat (3) step();
      resetn = 1'b1;
      repeat (200) step();
      rx = 1'b1;
      repeat (2400) step();
      rd(4'h4, "post_rst_status");
      rd(4'h8, "post_rst_div");
      rd(4'h0, "post_rst_data");
`endif
      repeat (2) step();
      check("scoreboard_drain", 32'(expq.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
